fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the controller and datapath in the ARM-subset core.
- Holds the PC and issues word fetches over a req/ack instruction-memory handshake.
- Registers the fetched word and presents it, with pre-sliced Cond/Op/Funct/Rd fields, until the core retires it.
- On retire, advances the PC to PC+4 or to the branch target selected by PCSrc.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over req/ack and
// presents it until retired. Optional perf counters are enabled with FETCH_PERF_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              fire;
  logic              take_ack;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] pc_nxt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = VALID;
      VALID:   if (instr_ready) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == VALID);
  end

  assign fire           = instr_valid & instr_ready;
  assign take_ack       = (state == FETCH) & imem_ack;
  // Branch targets are forced to word alignment rather than faulting.
  assign target_aligned = branch_target & ~ADDR_W'(3);
  assign pc_nxt         = pc_src ? target_aligned : pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      instr <= 32'd0;
    end else begin
      if (take_ack) instr <= imem_rdata;
      if (fire)     pc    <= pc_nxt;
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_plus8  = pc + ADDR_W'(8);
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (fire)                         perf_retired <= sat_inc(perf_retired);
      if ((state == FETCH) && !imem_ack) perf_stall  <= sat_inc(perf_stall);
    end
  end
`else
  // Counters are compiled out; the helper stays to keep one definition of saturation.
  logic [31:0] unused_sat;
  assign unused_sat = sat_inc(32'd0);
`endif

endmodule
